// File: rtl/uop_pkg.sv
// uop_pkg: op encodings and fixed per-op unit latencies shared by the issue path
package uop_pkg;
  typedef enum logic [1:0] {OP_AND, OP_SHL, OP_ADDSUB, OP_MUL} op_t;
  localparam int LAT_LUT = 0;
  localparam int LAT_DSP_ADDSUB = 2;
  localparam int LAT_DSP_MUL = 3;
  function automatic int op_latency(input op_t op);
    return op == OP_MUL ? LAT_DSP_MUL : op == OP_ADDSUB ? LAT_DSP_ADDSUB : LAT_LUT;
  endfunction
endpackage

// File: rtl/uop_sync_fifo.sv
// uop_sync_fifo: synchronous FIFO of any depth; push ignored when full, pop ignored when empty
module uop_sync_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic push_ok, pop_ok;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH-1) ? '0 : p + 1'b1;
  endfunction
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  assign rdata = mem[rptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) mem[wptr] <= wdata;
      if (push_ok) wptr <= nxt(wptr);
      if (pop_ok) rptr <= nxt(rptr);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/uop_issue_ctrl.sv
// uop_issue_ctrl: credit-gated issue into a fixed-latency microop_unit with result FIFO
// UOP_ISSUE_PERF_EN adds perf_issued/perf_stall counters.
module uop_issue_ctrl import uop_pkg::*; #(
  parameter int W = 64,
  parameter int TAG_W = 4,
  parameter int IQ_DEPTH = 4,
  parameter int LAT = LAT_LUT
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [$clog2(W)-1:0] in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic [$clog2(W)-1:0] op_shamt,
  input  logic [W-1:0] op_y,
  output logic out_valid,
  input  logic out_ready,
  output logic [W-1:0] out_y,
  output logic [TAG_W-1:0] out_tag
`ifdef UOP_ISSUE_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stall
`endif
);
  localparam int SW = $clog2(W);
  localparam int RD = LAT + 1;
  localparam int OW = $clog2(LAT + 2);
  logic [2*W+SW+TAG_W-1:0] q_rdata;
  logic [W-1:0] q_a, q_b;
  logic [SW-1:0] q_sh;
  logic [TAG_W-1:0] q_tag;
  logic q_full, q_empty, r_full, r_empty, issue, unused;
  logic [$clog2(IQ_DEPTH+1)-1:0] q_count;
  logic [OW-1:0] r_count, outstanding;
  logic [RD-1:0] vld;
  logic [TAG_W-1:0] ptag [RD];
  assign in_ready = !q_full;
  assign {q_a, q_b, q_sh, q_tag} = q_rdata;
  assign out_valid = !r_empty;
  assign unused = ^{q_count, r_full};
  uop_sync_fifo #(.DW(2*W+SW+TAG_W), .DEPTH(IQ_DEPTH)) u_iq (
    .clk(clk), .rst(rst), .push(in_valid && in_ready), .pop(issue),
    .wdata({in_a, in_b, in_shamt, in_tag}), .rdata(q_rdata),
    .full(q_full), .empty(q_empty), .count(q_count)
  );
  uop_sync_fifo #(.DW(W+TAG_W), .DEPTH(RD)) u_rq (
    .clk(clk), .rst(rst), .push(vld[RD-1]), .pop(out_valid && out_ready),
    .wdata({op_y, ptag[RD-1]}), .rdata({out_y, out_tag}),
    .full(r_full), .empty(r_empty), .count(r_count)
  );
  // Credits: live pipeline valids plus queued results; a pop frees its credit only after the edge.
  always_comb begin
    outstanding = r_count;
    for (int i = 0; i < RD; i++) outstanding = outstanding + OW'(vld[i]);
    issue = !q_empty && (outstanding < OW'(RD));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      op_a <= '0;
      op_b <= '0;
      op_shamt <= '0;
      for (int i = 0; i < RD; i++) ptag[i] <= '0;
    end else begin
      vld[0] <= issue;
      ptag[0] <= q_tag;
      for (int i = 1; i < RD; i++) vld[i] <= vld[i-1];
      for (int i = 1; i < RD; i++) ptag[i] <= ptag[i-1];
      if (issue) begin
        op_a <= q_a;
        op_b <= q_b;
        op_shamt <= q_sh;
      end
    end
  end
`ifdef UOP_ISSUE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued <= '0;
      perf_stall <= '0;
    end else begin
      perf_issued <= perf_issued + 32'(issue);
      perf_stall <= perf_stall + 32'(!q_empty && !issue);
    end
  end
`endif
endmodule

// File: tb/tb_uop_issue_ctrl.sv
// tb_uop_issue_ctrl: directed bench driving three controllers (LAT 0/2/3) with a y=a+b unit model
module tb_uop_issue_ctrl;
  import uop_pkg::*;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [63:0] in_a = 0, in_b = 0;
  logic [5:0] in_shamt = 0;
  logic [3:0] in_tag = 0;
  logic rdy [3], ovld [3];
  logic [63:0] opa [3], opb [3], opy [3], oy [3];
  logic [5:0] opsh [3];
  logic [3:0] otag [3];
`ifdef UOP_ISSUE_PERF_EN
  logic [31:0] piss [3], pstl [3];
  int m_q, m_out, m_iss, m_stall;
`endif
  int checks = 0, errors = 0, cyc = 0, sel = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = g == 0 ? LAT_LUT : g == 1 ? LAT_DSP_ADDSUB : LAT_DSP_MUL;
    logic [63:0] pipe [3];
    always @(posedge clk) begin
      pipe[0] <= opa[g] + opb[g];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign opy[g] = L == 0 ? opa[g] + opb[g] : pipe[L-1];
    uop_issue_ctrl #(.W(64), .TAG_W(4), .IQ_DEPTH(4), .LAT(L)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[g]),
      .in_a(in_a), .in_b(in_b), .in_shamt(in_shamt), .in_tag(in_tag),
      .op_a(opa[g]), .op_b(opb[g]), .op_shamt(opsh[g]), .op_y(opy[g]),
      .out_valid(ovld[g]), .out_ready(out_ready), .out_y(oy[g]), .out_tag(otag[g])
`ifdef UOP_ISSUE_PERF_EN
      , .perf_issued(piss[g]), .perf_stall(pstl[g])
`endif
    );
  end

`ifdef UOP_ISSUE_PERF_EN
  // Independent occupancy/credit model of the LAT=2 instance, evaluated on pre-edge values.
  always @(negedge clk) begin
    if (rst) begin
      m_q = 0; m_out = 0; m_iss = 0; m_stall = 0;
    end else begin
      automatic bit iss = m_q > 0 && m_out < 3;
      m_stall += (m_q > 0 && !iss) ? 1 : 0;
      m_iss += iss ? 1 : 0;
      m_q += ((in_valid && rdy[1]) ? 1 : 0) - (iss ? 1 : 0);
      m_out += (iss ? 1 : 0) - ((ovld[1] && out_ready) ? 1 : 0);
    end
  end
`endif

  typedef struct {
    logic [63:0] a, b;
    logic [5:0] sh;
    logic [3:0] tag;
    logic [63:0] y;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ey(input int t);
    return 64'(t * 3 + 1) + 64'(t + 100);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; out_ready = 0;
    step(); step();
    rst = 0;
  endtask

  task automatic drive(input int t);
    in_a = 64'(t * 3 + 1); in_b = 64'(t + 100); in_shamt = 6'(t); in_tag = 4'(t);
  endtask

  task automatic push_one(input int t, output int acc_cyc);
    bit acc = 0;
    drive(t);
    in_valid = 1;
    acc_cyc = -1;
    for (int c = 0; c < 20 && !acc; c++) begin
      acc = rdy[sel];
      step();
    end
    if (acc) acc_cyc = cyc;
    else chk("push_timeout", 64'(acc), 64'd1);
  endtask

  task automatic fill(output int n);
    n = 0;
    in_valid = 1;
    for (int c = 0; c < 30; c++) begin
      if (!rdy[sel] && n > 0) break;
      drive(n);
      begin
        automatic bit acc = rdy[sel];
        step();
        if (acc) n++;
      end
    end
    in_valid = 0;
  endtask

  task automatic collect(input int n, input int t0, input int budget, output int first_cyc);
    int got = 0;
    first_cyc = -1;
    for (int c = 0; c < budget && got < n; c++) begin
      if (ovld[sel] && out_ready) begin
        if (got == 0) first_cyc = cyc;
        chk("res_tag", 64'(otag[sel]), 64'(t0 + got));
        chk("res_y", oy[sel], ey(t0 + got));
        got++;
      end
      step();
    end
    chk("res_count", 64'(got), 64'(n));
    for (int c = 0; c < 8; c++) step();
    chk("no_extra", 64'(ovld[sel]), 64'd0);
  endtask

  initial begin
    int n, fc, ac, dummy;
    vecs[0] = '{a: 64'd5, b: 64'd7, sh: 6'd1, tag: 4'd3, y: 64'd12};
    vecs[1] = '{a: '1, b: 64'd1, sh: 6'd63, tag: 4'd15, y: 64'd0};
    vecs[2] = '{a: 64'h8000_0000_0000_0000, b: 64'h8000_0000_0000_0000, sh: 6'd0, tag: 4'd0, y: 64'd0};
    vecs[3] = '{a: 64'h1234, b: 64'h1111, sh: 6'd32, tag: 4'd9, y: 64'h2345};
    vecs[4] = '{a: 64'hDEAD_0000_0000_0001, b: 64'h0000_BEEF_0000_0002, sh: 6'd5, tag: 4'd6, y: 64'hDEAD_BEEF_0000_0003};

    do_reset();
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", 64'(rdy[k]), 64'd1);
      chk("rst_out_valid", 64'(ovld[k]), 64'd0);
      chk("rst_op_a", opa[k], 64'd0);
      chk("rst_op_b", opb[k], 64'd0);
      chk("rst_op_shamt", 64'(opsh[k]), 64'd0);
      chk("rst_out_y", oy[k], 64'd0);
      chk("rst_out_tag", 64'(otag[k]), 64'd0);
    end

    // LAT=0: single uops, result two cycles after accept
    sel = 0; out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      in_a = vecs[i].a; in_b = vecs[i].b; in_shamt = vecs[i].sh; in_tag = vecs[i].tag;
      in_valid = 1;
      step();
      in_valid = 0;
      step();
      chk("l0_valid_early", 64'(ovld[0]), 64'd0);
      chk("l0_op_shamt", 64'(opsh[0]), 64'(vecs[i].sh));
      step();
      chk("l0_valid", 64'(ovld[0]), 64'd1);
      chk("l0_y", oy[0], vecs[i].y);
      chk("l0_tag", 64'(otag[0]), 64'(vecs[i].tag));
    end

    // LAT=3: eight uops back to back, strict order, first result 5 cycles after accept
    do_reset();
    sel = 2; out_ready = 1; ac = -1;
    fork
      begin
        for (int t = 0; t < 8; t++) begin
          push_one(t, n);
          if (t == 0) ac = n;
        end
        in_valid = 0;
      end
      collect(8, 0, 80, fc);
    join
    chk("l3_first_latency", 64'(fc - ac), 64'd5);

    // LAT=2 stall: 3 in flight + 4 queued, then drain
    do_reset();
    sel = 1; out_ready = 0;
    fill(n);
    chk("stall_accepted", 64'(n), 64'd7);
    for (int c = 0; c < 4; c++) begin
      chk("stall_in_ready", 64'(rdy[1]), 64'd0);
      chk("stall_valid", 64'(ovld[1]), 64'd1);
      chk("stall_tag_hold", 64'(otag[1]), 64'd0);
      chk("stall_y_hold", oy[1], ey(0));
      step();
    end
    out_ready = 1;
    collect(7, 0, 60, dummy);
`ifdef UOP_ISSUE_PERF_EN
    chk("perf_issued", 64'(piss[1]), 64'd7);
    chk("perf_issued_model", 64'(piss[1]), 64'(m_iss));
    chk("perf_stall", 64'(pstl[1]), 64'(m_stall));
`endif

    // Full queue with credit freeing: push blocked on the issue cycle, accepted the next
    do_reset();
    sel = 1; out_ready = 0;
    fill(n);
    chk("fullq_accepted", 64'(n), 64'd7);
    drive(7);
    in_valid = 1;
    out_ready = 1;
    fork
      begin
        step();
        chk("fullq_ready_hold", 64'(rdy[1]), 64'd0);
        step();
        chk("fullq_ready_back", 64'(rdy[1]), 64'd1);
        step();
        in_valid = 0;
      end
      collect(8, 0, 80, dummy);
    join

    // Reset with two uops in the LAT=3 pipeline
    do_reset();
    sel = 2; out_ready = 1;
    push_one(0, n);
    push_one(1, n);
    in_valid = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("midrst_valid", 64'(ovld[2]), 64'd0);
    end
    push_one(5, n);
    in_valid = 0;
    collect(1, 5, 30, dummy);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end
endmodule
